// File: rtl/ifft8_pkg.sv
// Shared types and constants for the 8-point sequential DIF inverse FFT.
// Holds the packed Q8.8 complex word, the datapath widths, the conjugate
// twiddle table, the 3-bit bit-reversal helper and the FSM state encoding.
package ifft8_pkg;

  localparam int N      = 8;
  localparam int LOG2N  = 3;
  localparam int STAGES = LOG2N;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int FRAC   = 8;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // Conjugate twiddles e^{+j*2*pi*n/8}, n = 0..3, in Q8.8.
  localparam cplx_t TWIDDLE [4] = '{
    32'h0100_0000,
    32'h00b5_00b5,
    32'h0000_0100,
    32'hff4b_00b5
  };

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    CALC   = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/ifft8_dif_bfly.sv
// Combinational radix-2 DIF butterfly for the inverse FFT.
// Ports:
//   a, b   : complex inputs (a at the lower memory index)
//   tw     : conjugate twiddle applied to the difference term
//   a_out  : (a + b) / 2
//   b_out  : ((a - b) / 2) * tw
// The halving in every butterfly provides the overall 1/8 scaling.
module dif_bfly
  import ifft8_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  input  cplx_t tw,
  output cplx_t a_out,
  output cplx_t b_out
);

  // Sum or difference on a 17-bit signed intermediate, then an arithmetic
  // shift back to 16 bits; the halving guarantees the result fits.
  function automatic logic signed [DATA_W-1:0] half_sum(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] y,
    input logic                     sub
  );
    logic signed [DATA_W:0] ext;
    ext = sub ? ((DATA_W+1)'(x) - (DATA_W+1)'(y))
              : ((DATA_W+1)'(x) + (DATA_W+1)'(y));
    return ext[DATA_W:1];
  endfunction

  // Q8.8 x Q8.8 product truncated back to Q8.8 (bits [23:8], no rounding).
  function automatic logic signed [DATA_W-1:0] q88_mul(
    input logic signed [DATA_W-1:0] x,
    input logic signed [COEF_W-1:0] c
  );
    logic signed [DATA_W+COEF_W-1:0] p;
    p = (DATA_W+COEF_W)'(x) * (DATA_W+COEF_W)'(c);
    return p[DATA_W+FRAC-1:FRAC];
  endfunction

  logic signed [DATA_W-1:0] d_re;
  logic signed [DATA_W-1:0] d_im;

  always_comb begin
    a_out.re = half_sum(a.re, b.re, 1'b0);
    a_out.im = half_sum(a.im, b.im, 1'b0);
    d_re     = half_sum(a.re, b.re, 1'b1);
    d_im     = half_sum(a.im, b.im, 1'b1);
    b_out.re = q88_mul(d_re, tw.re) - q88_mul(d_im, tw.im);
    b_out.im = q88_mul(d_re, tw.im) + q88_mul(d_im, tw.re);
  end

endmodule

// File: rtl/ifft8_dif_seq.sv
// Sequential 8-point radix-2 DIF inverse FFT, scaled by 1/8.
// Loads 8 frequency samples serially, runs 12 in-place butterflies through
// one shared dif_bfly, then streams 8 time samples out in natural order.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_data/valid/ready  : X[k] input stream, {Re, Im} signed Q8.8
//   out_data/valid/ready : x[n] output stream, same format
//   out_last             : marks sample n = 7
module ifft8_dif_seq
  import ifft8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  state_t           state;
  state_t           state_nxt;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;
  logic [1:0]       stage;
  logic [1:0]       bfly_idx;
  logic [31:0]      mem [N];

  logic [LOG2N-1:0] lo_addr;
  logic [LOG2N-1:0] hi_addr;
  logic [1:0]       tw_sel;
  cplx_t            bf_a;
  cplx_t            bf_b;
  cplx_t            bf_tw;
  cplx_t            bf_a_out;
  cplx_t            bf_b_out;

  logic in_fire;
  logic out_fire;
  logic calc_done;

  assign in_ready  = (state == LOAD) && !rst;
  assign out_valid = (state == UNLOAD) && !rst;
  assign out_last  = out_valid && (rd_cnt == LOG2N'(N-1));
  assign out_data  = out_valid ? mem[bitrev3(rd_cnt)] : '0;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign calc_done = (state == CALC) && (stage == 2'(STAGES-1)) && (bfly_idx == 2'd3);

  // Pair addresses and twiddle index from stage and butterfly index:
  // stage 0 spans 4, stage 1 spans 2 inside each half, stage 2 spans 1.
  always_comb begin
    lo_addr = {1'b0, bfly_idx};
    hi_addr = {1'b1, bfly_idx};
    tw_sel  = bfly_idx;
    case (stage)
      2'd1: begin
        lo_addr = {bfly_idx[1], 1'b0, bfly_idx[0]};
        hi_addr = {bfly_idx[1], 1'b1, bfly_idx[0]};
        tw_sel  = {bfly_idx[0], 1'b0};
      end
      2'd2: begin
        lo_addr = {bfly_idx, 1'b0};
        hi_addr = {bfly_idx, 1'b1};
        tw_sel  = 2'd0;
      end
      default: ;
    endcase
  end

  assign bf_a  = mem[lo_addr];
  assign bf_b  = mem[hi_addr];
  assign bf_tw = TWIDDLE[tw_sel];

  dif_bfly u_bfly (
    .a     (bf_a),
    .b     (bf_b),
    .tw    (bf_tw),
    .a_out (bf_a_out),
    .b_out (bf_b_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && (wr_cnt == LOG2N'(N-1)))  state_nxt = CALC;
      CALC:    if (calc_done)                            state_nxt = UNLOAD;
      UNLOAD:  if (out_fire && (rd_cnt == LOG2N'(N-1))) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      stage    <= '0;
      bfly_idx <= '0;
    end else begin
      state <= state_nxt;
      if (in_fire) wr_cnt <= wr_cnt + 1'b1;
      if (out_fire) rd_cnt <= rd_cnt + 1'b1;
      if (state == CALC) begin
        bfly_idx <= bfly_idx + 2'd1;
        if (bfly_idx == 2'd3) stage <= calc_done ? 2'd0 : stage + 2'd1;
      end
    end
  end

  // Register file holds data only; its contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_cnt] <= in_data;
    end else if (state == CALC) begin
      mem[lo_addr] <= bf_a_out;
      mem[hi_addr] <= bf_b_out;
    end
  end

endmodule

// File: tb/tb_ifft8_dif_seq.sv
module tb_ifft8_dif_seq;

  typedef logic [31:0] frame_t [8];

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  real cos_t [8];
  real sin_t [8];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  ifft8_dif_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  // ---------------- reference model ----------------
  function automatic int wrap16(input int v);
    int r;
    r = v & 32'hFFFF;
    if (r >= 32768) r -= 65536;
    return r;
  endfunction

  function automatic int qmul(input int x, input int t);
    return wrap16((x * t) >>> 8);
  endfunction

  function automatic int bitrev(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  // Textbook DIF: for each stage, span halves; twiddle index = j * 2^stage.
  function automatic void ref_ifft(input frame_t xin, output frame_t y);
    int re [8];
    int im [8];
    int twr [4];
    int twi [4];
    twr = '{256, 181, 0, -181};
    twi = '{0, 181, 256, 181};
    for (int n = 0; n < 8; n++) begin
      re[n] = int'($signed(xin[n][31:16]));
      im[n] = int'($signed(xin[n][15:0]));
    end
    for (int s = 0; s < 3; s++) begin
      int span;
      span = 4 >> s;
      for (int base = 0; base < 8; base += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          int a, b, t, sr, si, dr, di;
          a  = base + j;
          b  = a + span;
          t  = j << s;
          sr = (re[a] + re[b]) >>> 1;
          si = (im[a] + im[b]) >>> 1;
          dr = (re[a] - re[b]) >>> 1;
          di = (im[a] - im[b]) >>> 1;
          re[a] = sr;
          im[a] = si;
          re[b] = wrap16(qmul(dr, twr[t]) - qmul(di, twi[t]));
          im[b] = wrap16(qmul(dr, twi[t]) + qmul(di, twr[t]));
        end
      end
    end
    for (int n = 0; n < 8; n++)
      y[n] = {16'(re[bitrev(n)]), 16'(im[bitrev(n)])};
  endfunction

  function automatic int rnd(input real v);
    return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
  endfunction

  // Forward DFT, X[k] = sum x[n] e^{-j 2 pi k n / 8}, rounded to Q8.8.
  function automatic void fwd_dft(input int xr [8], input int xi [8], output frame_t xf);
    for (int k = 0; k < 8; k++) begin
      real ar, ai;
      ar = 0.0;
      ai = 0.0;
      for (int n = 0; n < 8; n++) begin
        int m;
        m  = (k * n) % 8;
        ar += real'(xr[n]) * cos_t[m] + real'(xi[n]) * sin_t[m];
        ai += real'(xi[n]) * cos_t[m] - real'(xr[n]) * sin_t[m];
      end
      xf[k] = {16'(rnd(ar)), 16'(rnd(ai))};
    end
  endfunction

  // ---------------- stream drivers ----------------
  task automatic send_frame(input frame_t fr, input bit gaps, output int acc_cyc);
    int k = 0;
    int guard = 0;
    acc_cyc = -1;
    while (k < 8) begin
      @(negedge clk);
      if (gaps && ($urandom_range(0, 99) < 35)) begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_data  = fr[k];
      end
      if (in_valid && in_ready) begin
        acc_cyc = cycle;
        k++;
      end
      guard++;
      if (guard > 500) begin
        total++;
        bad++;
        $display("FAIL send_timeout: accepted %0d beats, need 8", k);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic recv_frame(input bit stall, output frame_t got, output int first_cyc);
    int n = 0;
    int guard = 0;
    bit pv = 1'b0;
    bit pr = 1'b0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    first_cyc = -1;
    for (int i = 0; i < 8; i++) got[i] = '0;
    while (n < 8) begin
      @(negedge clk);
      out_ready = stall ? ($urandom_range(0, 99) < 50) : 1'b1;
      in_valid  = $urandom_range(0, 1) != 0;
      in_data   = $urandom;
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cycle;
        if (pv && !pr) begin
          total++;
          if (out_data !== pd || out_last !== pl) begin
            bad++;
            $display("FAIL stall_hold: data=%h last=%b, need data=%h last=%b", out_data, out_last, pd, pl);
          end
        end
        if (out_ready) begin
          total++;
          if (out_last !== 1'(n == 7)) begin
            bad++;
            $display("FAIL out_last beat %0d: got %b need %b", n, out_last, (n == 7));
          end
          got[n] = out_data;
          n++;
        end
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pl = out_last;
      guard++;
      if (guard > 500) begin
        total++;
        bad++;
        $display("FAIL recv_timeout: got %0d beats, need 8", n);
        break;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_frame: in_ready=%b need 1", in_ready);
    end
  endtask

  function automatic void rand_frame(output frame_t fr);
    for (int i = 0; i < 8; i++) fr[i] = $urandom;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total += 4;
    if (in_ready !== 1'b0)  begin bad++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    if (out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last: got %b need 0", out_last); end
    if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data: got %h need 0", out_data); end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b need 1", in_ready); end
  endtask

  task automatic test_impulse();
    frame_t fr, got;
    int acc, first;
    for (int i = 0; i < 8; i++) fr[i] = '0;
    fr[0] = 32'h0100_0000;
    send_frame(fr, 1'b0, acc);
    recv_frame(1'b0, got, first);
    total++;
    if (first - acc !== 13) begin
      bad++;
      $display("FAIL impulse_latency: got %0d cycles need 13", first - acc);
    end
    for (int n = 0; n < 8; n++) begin
      total++;
      if (got[n] !== 32'h0020_0000) begin
        bad++;
        $display("FAIL impulse x[%0d]: got %h need 00200000", n, got[n]);
      end
    end
  endtask

  task automatic test_dc();
    frame_t fr, got;
    int acc, first;
    for (int i = 0; i < 8; i++) fr[i] = 32'h0100_0000;
    send_frame(fr, 1'b0, acc);
    recv_frame(1'b0, got, first);
    for (int n = 0; n < 8; n++) begin
      logic [31:0] exp_w;
      exp_w = (n == 0) ? 32'h0100_0000 : 32'h0;
      total++;
      if (got[n] !== exp_w) begin
        bad++;
        $display("FAIL dc x[%0d]: got %h need %h", n, got[n], exp_w);
      end
    end
  endtask

  task automatic test_tone();
    frame_t fr, got, mdl;
    int acc, first;
    int er [8];
    int ei [8];
    er = '{256, 181, 0, 0, -256, 0, 0, 0};
    ei = '{0, 181, 256, 0, 0, 0, -256, 0};
    for (int i = 0; i < 8; i++) fr[i] = '0;
    fr[1] = 32'h0800_0000;
    send_frame(fr, 1'b0, acc);
    recv_frame(1'b0, got, first);
    ref_ifft(fr, mdl);
    for (int n = 0; n < 8; n++) begin
      int gr, gi;
      gr = int'($signed(got[n][31:16]));
      gi = int'($signed(got[n][15:0]));
      if (n == 0 || n == 1 || n == 2 || n == 4 || n == 6) begin
        total++;
        if (gr < er[n] - 2 || gr > er[n] + 2 || gi < ei[n] - 2 || gi > ei[n] + 2) begin
          bad++;
          $display("FAIL tone_tol x[%0d]: got (%0d,%0d) need (%0d,%0d)+-2", n, gr, gi, er[n], ei[n]);
        end
      end
      total++;
      if (got[n] !== mdl[n]) begin
        bad++;
        $display("FAIL tone_exact x[%0d]: got %h need %h", n, got[n], mdl[n]);
      end
    end
  endtask

  task automatic test_random_frames();
    frame_t fr, got, mdl;
    int acc, first;
    for (int f = 0; f < 6; f++) begin
      rand_frame(fr);
      send_frame(fr, f[0], acc);
      recv_frame(1'b0, got, first);
      ref_ifft(fr, mdl);
      for (int n = 0; n < 8; n++) begin
        total++;
        if (got[n] !== mdl[n]) begin
          bad++;
          $display("FAIL random f%0d x[%0d]: got %h need %h", f, n, got[n], mdl[n]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    frame_t fr, got_a, got_b, mdl;
    int acc, first;
    for (int f = 0; f < 3; f++) begin
      rand_frame(fr);
      ref_ifft(fr, mdl);
      send_frame(fr, 1'b0, acc);
      recv_frame(1'b0, got_a, first);
      send_frame(fr, 1'b1, acc);
      recv_frame(1'b1, got_b, first);
      for (int n = 0; n < 8; n++) begin
        total++;
        if (got_b[n] !== got_a[n] || got_b[n] !== mdl[n]) begin
          bad++;
          $display("FAIL backpressure f%0d x[%0d]: got %h nostall %h need %h", f, n, got_b[n], got_a[n], mdl[n]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    frame_t fr, got, mdl;
    int acc, first;
    bit seen;
    rand_frame(fr);
    send_frame(fr, 1'b0, acc);
    while (cycle < acc + 5) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL midcalc_rst_in_ready: got %b need 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total += 3;
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL midcalc_in_ready: got %b need 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midcalc_out_valid: got %b need 0", out_valid); end
    if (out_data !== 32'h0) begin bad++; $display("FAIL midcalc_out_data: got %h need 0", out_data); end
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    total++;
    if (seen) begin bad++; $display("FAIL midcalc_no_output: out_valid seen=1 need 0"); end
    rand_frame(fr);
    send_frame(fr, 1'b0, acc);
    recv_frame(1'b0, got, first);
    ref_ifft(fr, mdl);
    for (int n = 0; n < 8; n++) begin
      total++;
      if (got[n] !== mdl[n]) begin
        bad++;
        $display("FAIL after_reset x[%0d]: got %h need %h", n, got[n], mdl[n]);
      end
    end
  endtask

  task automatic test_round_trip();
    frame_t xf, got;
    int acc, first;
    int xr [8];
    int xi [8];
    for (int f = 0; f < 1000; f++) begin
      for (int n = 0; n < 8; n++) begin
        xr[n] = int'($urandom_range(0, 1022)) - 511;
        xi[n] = int'($urandom_range(0, 1022)) - 511;
      end
      fwd_dft(xr, xi, xf);
      send_frame(xf, 1'b0, acc);
      recv_frame(1'b0, got, first);
      for (int n = 0; n < 8; n++) begin
        int gr, gi;
        gr = int'($signed(got[n][31:16]));
        gi = int'($signed(got[n][15:0]));
        total += 2;
        if (gr < xr[n] - 4 || gr > xr[n] + 4) begin
          bad++;
          $display("FAIL round_trip_re f%0d n%0d: got %0d need %0d+-4", f, n, gr, xr[n]);
        end
        if (gi < xi[n] - 4 || gi > xi[n] + 4) begin
          bad++;
          $display("FAIL round_trip_im f%0d n%0d: got %0d need %0d+-4", f, n, gi, xi[n]);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int m = 0; m < 8; m++) begin
      cos_t[m] = $cos(2.0 * 3.14159265358979 * real'(m) / 8.0);
      sin_t[m] = $sin(2.0 * 3.14159265358979 * real'(m) / 8.0);
    end
    test_reset();
    test_impulse();
    test_dc();
    test_tone();
    test_random_frames();
    test_backpressure();
    test_reset_mid_calc();
    test_round_trip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
